// File: rtl/kb_pkg.sv
// Shared types and helpers for the keypad scan controller.
// Holds the scan FSM state encoding, key-code width, idle column pattern,
// and small combinational helpers for column drive, row priority and code packing.
package kb_pkg;

    localparam int         KEY_W    = 4;
    localparam logic [3:0] COL_IDLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        DEBOUNCE = 2'd2,
        HELD     = 2'd3
    } kb_state_t;

    // Active-low one-cold drive pattern for a column index.
    function automatic logic [3:0] kb_col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    // Index of the lowest-numbered row that is pulled low; 0 when none is low,
    // so callers must qualify it with a separate "any pressed" test.
    function automatic logic [1:0] kb_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Key code layout: {row[1:0], col[1:0]}.
    function automatic logic [KEY_W-1:0] kb_pack_code(input logic [1:0] row,
                                                      input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/kb_key_fifo.sv
// Purpose : synchronous show-ahead FIFO for debounced key codes.
// Latency : a push is visible at the head one cycle later; o_head_dat is registered.
// Backpr. : no stall; a push into a full FIFO is ignored unless a pop happens the same cycle.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_push/i_push_dat write strobe and data
//   i_pop            consume head; ignored when empty
//   o_head_dat       current head (holds the last head value when empty)
//   o_count          number of stored entries
//   o_full/o_empty   occupancy flags
module kb_key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [W-1:0]     w_head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    // Full is fine as long as the head leaves in the same cycle.
    assign w_push  = i_push && (!w_full || w_pop);

    assign w_rd_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // The head register tracks the entry the read pointer will point at next.
    // If that slot is being written this very cycle the memory does not hold
    // it yet, so the incoming data is forwarded instead.
    always_comb begin
        w_head_nxt = r_head;
        if (w_count_nxt != '0) begin
            if (w_push && (w_rd_nxt == r_wr_ptr)) begin
                w_head_nxt = i_push_dat;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
        end
    end

    assign o_head_dat = r_head;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

endmodule

// File: rtl/kb_scan_ctrl.sv
// Purpose : 4x4 keypad scan sequencer with press/release debounce and a key-code FIFO.
// Latency : code pushed on the tick completing the debounce; key_valid rises one cycle later.
// Backpr. : none toward the keypad; a push into a full FIFO is dropped and flagged in overflow.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   scan_en         1 = scan the matrix, 0 = park in IDLE with all columns released
//   kb_row          raw active-low row inputs (asynchronous to clk)
//   kb_column       active-low column drive, one-cold while scanning, 4'hF when idle
//   key_code        FIFO head {row, col}; key_valid = FIFO not empty
//   key_pop         consume the head
//   fifo_count      FIFO occupancy
//   overflow        sticky dropped-push flag, cleared by ovf_clr (a new drop wins)
module kb_scan_ctrl
    import kb_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        scan_en,
    input  logic [3:0]                  kb_row,
    output logic [3:0]                  kb_column,
    output logic [KEY_W-1:0]            key_code,
    output logic                        key_valid,
    input  logic                        key_pop,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        ovf_clr
);

    // DWELL must be at least 4 and DEBOUNCE_SCANS within 2..15.
    localparam int         DWELL      = CLK_FREQ / SCAN_HZ;
    localparam int         CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [3:0] DBC_TARGET = 4'(DEBOUNCE_SCANS);

    kb_state_t        r_state;
    logic [1:0]       r_col;
    logic [3:0]       r_column;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [3:0]       r_dbc;
    logic [3:0]       r_rel;
    logic [1:0]       r_cand_row;
    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    logic             r_overflow;

    logic             w_tick;
    logic             w_pressed;
    logic [1:0]       w_low_row;
    logic [1:0]       w_col_nxt;
    logic             w_cand_match;
    logic             w_dbc_done;
    logic             w_rel_done;
    logic             w_push;
    logic [KEY_W-1:0] w_push_code;
    logic             w_drop;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    // Two-flop synchronizer for the asynchronous row inputs. Reset to
    // "all released" so nothing looks pressed straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= kb_row;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_tick       = (r_tick_cnt == CNT_W'(DWELL - 1));
    assign w_pressed    = ~&r_row_s2;
    assign w_low_row    = kb_low_row(r_row_s2);
    assign w_col_nxt    = r_col + 2'd1;
    assign w_cand_match = w_pressed && (w_low_row == r_cand_row);
    assign w_dbc_done   = ((r_dbc + 4'd1) == DBC_TARGET);
    assign w_rel_done   = ((r_rel + 4'd1) == DBC_TARGET);

    // The push fires on the same tick that moves DEBOUNCE into HELD.
    // Dropping scan_en on that very cycle discards the press.
    assign w_push      = !reset && scan_en && (r_state == DEBOUNCE) &&
                         w_tick && w_cand_match && w_dbc_done;
    assign w_push_code = kb_pack_code(r_cand_row, r_col);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_col      <= 2'd0;
            r_column   <= COL_IDLE;
            r_tick_cnt <= '0;
            r_dbc      <= 4'd0;
            r_rel      <= 4'd0;
            r_cand_row <= 2'd0;
        end else if (!scan_en) begin
            r_state    <= IDLE;
            r_column   <= COL_IDLE;
            r_tick_cnt <= '0;
            r_dbc      <= 4'd0;
            r_rel      <= 4'd0;
        end else begin
            // The dwell counter free-runs while scanning and wraps on the tick;
            // every column change happens on a tick, so the wrap is the clear.
            if (r_state != IDLE) begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    r_state    <= SCAN;
                    r_col      <= 2'd0;
                    r_column   <= kb_col_drive(2'd0);
                    r_tick_cnt <= '0;
                end

                SCAN: begin
                    if (w_tick) begin
                        if (w_pressed) begin
                            r_cand_row <= w_low_row;
                            r_dbc      <= 4'd1;
                            r_state    <= DEBOUNCE;
                        end else begin
                            r_col    <= w_col_nxt;
                            r_column <= kb_col_drive(w_col_nxt);
                        end
                    end
                end

                DEBOUNCE: begin
                    if (w_tick) begin
                        if (w_cand_match) begin
                            if (w_dbc_done) begin
                                r_state <= HELD;
                                r_dbc   <= 4'd0;
                                r_rel   <= 4'd0;
                            end else begin
                                r_dbc <= r_dbc + 4'd1;
                            end
                        end else begin
                            // Bounce or a different row: give up on this column.
                            r_state  <= SCAN;
                            r_dbc    <= 4'd0;
                            r_col    <= w_col_nxt;
                            r_column <= kb_col_drive(w_col_nxt);
                        end
                    end
                end

                HELD: begin
                    // Only a full run of released ticks ends the hold; any
                    // low row restarts the release count. No auto-repeat.
                    if (w_tick) begin
                        if (w_pressed) begin
                            r_rel <= 4'd0;
                        end else if (w_rel_done) begin
                            r_rel    <= 4'd0;
                            r_state  <= SCAN;
                            r_col    <= w_col_nxt;
                            r_column <= kb_col_drive(w_col_nxt);
                        end else begin
                            r_rel <= r_rel + 4'd1;
                        end
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_column <= COL_IDLE;
                end
            endcase
        end
    end

    kb_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_code),
        .i_pop      (key_pop),
        .o_head_dat (key_code),
        .o_count    (fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // A full FIFO still accepts a push when the head is popped alongside it.
    assign w_drop = w_push && w_fifo_full && !key_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign kb_column = r_column;
    assign key_valid = ~w_fifo_empty;
    assign overflow  = r_overflow;

endmodule
